// File: rtl/phy_tx_pkg.sv
// Shared word width, default FIFO sizing and helpers for the TX word path.
// Imported by the FIFO top and its storage sub-module.
package phy_tx_pkg;

  localparam int WORD_W                  = 32;
  localparam int DEFAULT_DEPTH           = 8;
  localparam int DEFAULT_ALMOST_FULL_TH  = 6;
  localparam int DEFAULT_ALMOST_EMPTY_TH = 2;

  typedef logic [WORD_W-1:0] word_t;

  // Accepted-operation classes; their bit patterns match {push_ok, pop_ok}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Occupancy needs one more bit than a pointer so that DEPTH itself fits.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Word storage for tx_word_fifo: one registered write port, one asynchronous read port.
// Contents are deliberately not reset; the top never reads an unwritten entry.
module fifo_mem
  import phy_tx_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEFAULT_DEPTH)
) (
  input  logic          clk_2f,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  word_t         wr_data,
  input  logic [AW-1:0] rd_addr,
  output word_t         rd_data
);

  word_t mem_q [DEPTH];

  always_ff @(posedge clk_2f) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/tx_word_fifo.sv
// Circular word FIFO feeding the byte striper: registered 1-cycle read, occupancy flags,
// and a sticky overflow indicator. Synchronous active-low reset.
module tx_word_fifo
  import phy_tx_pkg::*;
#(
  parameter int DEPTH           = DEFAULT_DEPTH,
  parameter int ALMOST_FULL_TH  = DEFAULT_ALMOST_FULL_TH,
  parameter int ALMOST_EMPTY_TH = DEFAULT_ALMOST_EMPTY_TH
) (
  input  logic                          clk_2f,
  input  logic                          reset_L,
  input  logic [WORD_W-1:0]             data_in,
  input  logic                          push,
  input  logic                          pop,
  output logic [WORD_W-1:0]             data_out,
  output logic                          valid_out,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  word_t         data_out_q, data_out_d;
  logic          valid_out_q, valid_out_d;
  logic          overflow_q, overflow_d;

  logic     push_ok;
  logic     pop_ok;
  word_t    rd_data;
  fifo_op_e op;

  fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_2f  (clk_2f),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(ALMOST_FULL_TH));
  assign almost_empty = (count_q <= CW'(ALMOST_EMPTY_TH));

  // A push at full is still accepted when a pop frees the head slot on the same edge.
  // On an empty FIFO the pop is refused, so push+pop simply stores the word (no bypass).
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign op      = fifo_op_e'({push_ok, pop_ok});

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = '0;
    valid_out_d = 1'b0;
    overflow_d  = overflow_q || (push && full && !pop);

    unique case (op)
      OP_PUSH: begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_q + CW'(1);
      end
      OP_POP: begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        count_d  = count_q - CW'(1);
      end
      OP_BOTH: begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      default: ;
    endcase

    if (pop_ok) begin
      data_out_d  = rd_data;
      valid_out_d = 1'b1;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (!reset_L) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign data_out     = data_out_q;
  assign valid_out    = valid_out_q;
  assign count        = count_q;
  assign overflow_err = overflow_q;

endmodule

// File: doc/tx_word_fifo.md
TX_WORD_FIFO -- requirements
Module: tx_word_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of 32-bit word entries; power of two, at least 4.
REQ-002 Parameter ALMOST_FULL_TH, default 6, occupancy at or above which almost_full asserts.
REQ-003 Parameter ALMOST_EMPTY_TH, default 2, occupancy at or below which almost_empty asserts.
REQ-004 The block SHALL have these ports:
- clk_2f  input  1  single clock, rising edge; reset is synchronous and active-low.
- reset_L  input  1  synchronous active-low reset, sampled on the rising edge of clk_2f.
- data_in  input  32  word from the upstream source.
- push  input  1  write request; data_in is captured on the same edge.
- pop  input  1  read request from the byte-striping stage.
- data_out  output  32  registered word toward the striper's data_in.
- valid_out  output  1  registered qualifier toward the striper's valid_in.
- full, empty  output  1 each  occupancy flags.
- almost_full, almost_empty  output  1 each  threshold flags for upstream pacing.
- count  output  clog2(DEPTH)+1  current occupancy.
- overflow_err  output  1  sticky: a push occurred while full.

Function
REQ-005 Storage SHALL be a circular buffer with write and read pointers of clog2(DEPTH) bits; each pointer wraps from DEPTH-1 to 0.
REQ-006 A push while not full SHALL write data_in at the write pointer and advance the write pointer on the same edge.
REQ-007 A pop while not empty SHALL load the head word into data_out and set valid_out=1 on the next edge; read latency is 1 cycle.
REQ-008 A pop while empty, or any cycle without pop, SHALL drive valid_out=0 and data_out=32'h00000000 on the next edge.
REQ-009 A push while full and pop=0 SHALL be dropped, leave storage and count unchanged, and set overflow_err=1.
REQ-010 push=1 and pop=1 while full SHALL perform both operations: the pop reads the head word, the push is accepted into the freed slot, count is unchanged, and overflow_err is not set.
REQ-011 push=1 and pop=1 while empty SHALL store the word with no bypass; valid_out=0 on the next edge; count becomes 1.
REQ-012 push=1 and pop=1 with 0<count<DEPTH SHALL perform both operations; count is unchanged.
REQ-013 count SHALL be a registered value that increments on an accepted push, decrements on an accepted pop, and never exceeds DEPTH or goes below 0.
REQ-014 Flags SHALL be derived combinationally from the registered count:
- full = (count == DEPTH)
- empty = (count == 0)
- almost_full = (count >= ALMOST_FULL_TH)
- almost_empty = (count <= ALMOST_EMPTY_TH)
REQ-015 overflow_err SHALL stay 1 until reset; pops do not clear it.

Reset
REQ-016 With reset_L=0 at a rising edge, the block SHALL set:
- both pointers = 0, count = 0
- data_out = 0, valid_out = 0, overflow_err = 0
REQ-017 Reset asserted mid-operation SHALL discard all stored words; push and pop are ignored while reset_L=0.
REQ-018 Storage array contents need not be reset; no unwritten entry SHALL ever reach data_out.
REQ-019 During reset and after release, flags SHALL read empty=1, almost_empty=1, full=0, almost_full=0.

Structure
REQ-020 A shared package (phy_tx_pkg) SHALL hold the shared constants and types:
- WORD_W = 32
- default DEPTH and both default thresholds
- the count-width function
REQ-021 The storage array SHALL be a sub-module, fifo_mem: one registered write port and one read port addressed by the read pointer; all pointer, count and flag logic stays in tx_word_fifo.

Verification
REQ-022 Fill/drain: after reset, push 8 words 0x11111111..0x88888888 with no pop -> full=1, count=8; then pop 8 cycles -> same words in order, each 1 cycle after its pop, valid_out=1 throughout, then empty=1.
REQ-023 Overflow: with the FIFO full, push 0xDEADBEEF with pop=0 -> count stays 8, overflow_err=1; draining the FIFO never outputs 0xDEADBEEF.
REQ-024 Simultaneous at full: count=8 and push+pop with 0xCAFEF00D -> count stays 8, overflow_err=0; 0xCAFEF00D emerges as the 8th subsequent pop.
REQ-025 Empty edge: push+pop together on an empty FIFO with 0x0000A5A5 -> valid_out=0 next cycle, count=1; the next pop yields 0x0000A5A5.
REQ-026 Wrap and thresholds: run 20 push-then-pop pairs -> data stays in order across pointer wrap; almost_full rises at count 6 and almost_empty falls at count 3.
REQ-027 Mid-operation reset: reset_L=0 for one cycle with count=5 -> count=0, empty=1, valid_out=0, data_out=0, overflow_err=0.
